shared_bus_arbiter: RTL
=======================

// Module: shared_bus_arbiter
// PURPOSE
//  Round-robin arbiter owning one shared tristate data bus driven by NUM_REQ sources.
//  Produces one-hot, registered drive enables that feed each source's tristate buffer enable.
//  Inserts one all-off turnaround cycle between owners so two drivers never overlap.
//  Bounds each tenure to MAX_HOLD cycles when another source is waiting.
//  Sits between bus masters (CPU, sprite engine, VGA fetch) and the shared bus.
// PARAMETERS
//  NUM_REQ   4  number of requesters (>=2)
//  MAX_HOLD  8  max consecutive OWN cycles while another req is pending (>=1)
//  ID_W      2  width of owner_id; must be >= clog2(NUM_REQ)
// PORTS
//  clock        in   1        single clock; all state updates on rising edge
//  reset_n      in   1        synchronous, active-low reset
//  req          in   NUM_REQ  req[i]=1: source i wants the bus; held high for the whole tenure
//  grant        out  NUM_REQ  one-hot drive enable to source i tristate; registered
//  owner_valid  out  1        1 while any grant bit is set
//  owner_id     out  ID_W     index of current owner; 0 when owner_valid=0
//  turnaround   out  1        1 during the single bus-floating gap cycle
// BEHAVIOUR
//  Reset (reset_n=0 at an edge):
//   - grant=0, owner_valid=0, owner_id=0, turnaround=0.
//   - state=IDLE, hold_cnt=0, last_owner=NUM_REQ-1.
//   - Reset dominates every other event, including reset during OWN; no turnaround is inserted.
//  States: IDLE, OWN, TURN. All outputs are registered and decoded from state.
//  IDLE:
//   - grant=0. If req!=0 at edge k, pick winner W; grant[W]=1 and state=OWN from edge k.
//   - Latency: 1 cycle from req sampled to grant visible.
//  Winner selection: round-robin scan from last_owner+1 upward, wrapping at NUM_REQ-1 -> 0.
//   - last_owner is scanned last, so it has lowest priority.
//   - last_owner <= W on every grant.
//  OWN:
//   - grant=onehot(owner); hold_cnt increments each cycle and saturates at MAX_HOLD-1.
//   - Release when req[owner]==0: next state TURN.
//   - Preempt when hold_cnt==MAX_HOLD-1 and (req & ~onehot(owner))!=0: next state TURN.
//   - If hold expires with no other requester, ownership continues (hold_cnt stays saturated).
//     Preemption occurs on the first edge another req is seen.
//  TURN (exactly 1 cycle):
//   - grant=0, turnaround=1, hold_cnt=0.
//   - At the end of the cycle: if req!=0, arbitrate and go to OWN; else go to IDLE.
//   - A preempted owner still requesting re-enters arbitration with lowest priority.
//  Invariants:
//   - grant is one-hot or zero.
//   - grant changes between two different owners only through a grant==0 cycle.
//   - A req deasserting for a non-owner has no effect.
//   - Glitches on req for any i never change grant mid-tenure, except the owner's own release.
//  hold_cnt width is clog2(MAX_HOLD)+1 bits; no wrap is possible because it saturates.
// TESTING
//  1. reset_n=0 for 2 cycles with req=4'b1111 -> grant=0 throughout; first cycle after reset grant=4'b0001, owner_id=0.
//  2. req=4'b0100 for 3 cycles then 0 -> grant=0100 for 3 cycles, then 1 cycle grant=0 with turnaround=1, then IDLE (grant=0).
//  3. req=4'b1111 held 40 cycles, MAX_HOLD=8 -> 0001,0010,0100,1000 each for 8 cycles, separated by single zero cycles; check one-hot every cycle.
//  4. Owner 1 drops req while req[3]=1 -> next cycle grant=0 and turnaround=1; following cycle grant=1000, owner_id=3.
//  5. req=4'b0001 only, held 20 cycles -> grant=0001 for all 20 cycles, with no preemption past MAX_HOLD.
//  6. reset_n=0 mid-OWN (owner 2) -> grant=0 at next edge; then req=4'b1010 -> grant=0010, confirming the pointer was reset.

Source files
------------

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner of a shared tristate bus. Grants are one-hot and registered,
// each change of owner passes through a single all-off turnaround cycle, and a
// tenure is cut short after MAX_HOLD cycles only when another source is waiting.
//
// Handshake: req[i] is a level request. A source raises it and holds it high
// for its whole tenure. grant[i] is the registered drive enable for source i.
// A source owns the bus for exactly the cycles in which grant[i]=1. Dropping
// req[i] while owning releases the bus at the next edge. The arbiter ignores
// req changes from non-owners until the next arbitration point.
module shared_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               owner_valid,
    output logic [ID_W-1:0]    owner_id,
    output logic               turnaround
);

    localparam int HC_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t          state;
    logic [HC_W-1:0] hold_cnt;
    logic [ID_W-1:0] last_owner;

    logic [ID_W-1:0] pick_id;
    logic            pick_found;
    logic [ID_W:0]   scan_idx;
    logic            release_now;
    logic            preempt_now;

    // Round-robin scan starting just after last_owner; last_owner is visited last
    always_comb begin
        pick_id    = '0;
        pick_found = 1'b0;
        scan_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = {1'b0, last_owner} + (ID_W+1)'(i);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!pick_found && req[scan_idx[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    // Reasons to end the current tenure; only meaningful in ST_OWN
    always_comb begin
        release_now = !req[owner_id];
        preempt_now = (hold_cnt == HOLD_LAST) && (|(req & ~grant));
    end

    // Arbiter FSM with registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            last_owner  <= ID_W'(NUM_REQ - 1);
            grant       <= '0;
            owner_valid <= 1'b0;
            owner_id    <= '0;
            turnaround  <= 1'b0;
        end else begin
            case (state)
                ST_OWN: begin
                    if (release_now || preempt_now) begin
                        state       <= ST_TURN;
                        grant       <= '0;
                        owner_valid <= 1'b0;
                        owner_id    <= '0;
                        turnaround  <= 1'b1;
                        hold_cnt    <= '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    // ST_IDLE and ST_TURN both arbitrate at the end of the cycle
                    turnaround <= 1'b0;
                    hold_cnt   <= '0;
                    if (pick_found) begin
                        state       <= ST_OWN;
                        grant       <= NUM_REQ'(1) << pick_id;
                        owner_valid <= 1'b1;
                        owner_id    <= pick_id;
                        last_owner  <= pick_id;
                    end else begin
                        state       <= ST_IDLE;
                        grant       <= '0;
                        owner_valid <= 1'b0;
                        owner_id    <= '0;
                    end
                end
            endcase
        end
    end

endmodule
